// File: rtl/mon_uart_pkg.sv
// mon_uart_pkg: shared definitions for the board-monitor UART exporter.
//   byte_state_t : byte-serialiser FSM states (IDLE, START, DATA, STOP)
//   ASCII_CR/LF  : line terminator characters
//   hex2ascii()  : 4-bit nibble -> uppercase ASCII hex digit
package mon_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } byte_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // 0-9 -> '0'..'9' (0x30..0x39), 10-15 -> 'A'..'F' (0x41..0x46)
    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else begin
            c = 8'h37 + {4'h0, nib};
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser.
//   clk, reset : board clock, synchronous active-high reset
//   load       : present a byte; taken when ready=1 or in the byte_done cycle
//   byte_in    : byte to send (LSB first)
//   tx         : registered serial line, idle high
//   ready      : serialiser idle
//   byte_done  : one-cycle strobe during the final cycle of the stop bit
// Parameter DIV: clock cycles per bit (>= 2).
module uart_tx_byte
    import mon_uart_pkg::*;
#(
    parameter int unsigned DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       ready,
    output logic       byte_done
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    byte_state_t   state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign ready     = (state == IDLE);
    // Combinational so the sequencer can reload on the same edge the stop
    // bit ends: the next start bit then follows with no idle gap.
    assign byte_done = (state == STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else if (load && (ready || byte_done)) begin
            state    <= START;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= byte_in;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        tx       <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mon_uart_tx.sv
// mon_uart_tx: exports a 32-bit monitor word as 8 uppercase hex ASCII
// characters (plus CR LF when MON_UART_CRLF_EN is defined) over 8N1 UART.
//   clk, reset : 100 MHz board clock, synchronous active-high reset
//   data       : word to export, sampled on an accepted send
//   send       : request, accepted on an edge while busy=0
//   tx         : UART line, idle high
//   busy       : word in progress
//   done       : one-cycle pulse after the last stop bit
// Parameters CLK_HZ, BAUD: bit period DIV = CLK_HZ/BAUD cycles.
// Macro MON_UART_CRLF_EN: append CR LF (10 characters instead of 8).
module mon_uart_tx
    import mon_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        send,
    output logic        tx,
    output logic        busy,
    output logic        done
);

`ifdef MON_UART_CRLF_EN
    localparam int unsigned N = 10;
`else
    localparam int unsigned N = 8;
`endif
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned DIV   = CLK_HZ / BAUD;

    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] index_nx;
    logic [31:0]      shadow;
    logic             accept;
    logic             more;
    logic             byte_load;
    logic             byte_ready;
    logic             byte_done;
    logic [7:0]       byte_sel;

    assign index_nx  = index + IDX_W'(1);
    assign accept    = send && !busy && byte_ready;
    assign more      = (index != IDX_W'(N - 1));
    assign byte_load = accept || (byte_done && more);

    // The shadow register shifts left one nibble per character, so the
    // next digit to send is always shadow[31:28]; the first digit comes
    // straight from data on the accept edge.
    always_comb begin
        byte_sel = hex2ascii(data[31:28]);
        if (!accept) begin
            byte_sel = hex2ascii(shadow[31:28]);
`ifdef MON_UART_CRLF_EN
            if (index_nx == IDX_W'(8)) begin
                byte_sel = ASCII_CR;
            end else if (index_nx == IDX_W'(9)) begin
                byte_sel = ASCII_LF;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            index  <= '0;
            shadow <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy   <= 1'b1;
                index  <= '0;
                shadow <= {data[27:0], 4'h0};
            end else if (byte_done) begin
                if (more) begin
                    index  <= index_nx;
                    shadow <= {shadow[27:0], 4'h0};
                end else begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_byte (
        .clk      (clk),
        .reset    (reset),
        .load     (byte_load),
        .byte_in  (byte_sel),
        .tx       (tx),
        .ready    (byte_ready),
        .byte_done(byte_done)
    );

endmodule

// File: tb/tb_mon_uart_tx.sv
// tb_mon_uart_tx: randomized scoreboard bench for mon_uart_tx at DIV=10.
// A posedge model predicts accepts and pushes expected characters and
// done times; a negedge monitor decodes the UART line, pops and compares,
// and checks the predicted per-cycle tx/busy/done levels.
module tb_mon_uart_tx;

`ifdef MON_UART_CRLF_EN
    localparam int N = 10;
`else
    localparam int N = 8;
`endif
    localparam int DIV = 10;
    localparam int W   = N * 10 * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data;
    logic        send;
    logic        tx;
    logic        busy;
    logic        done;

    mon_uart_tx #(
        .CLK_HZ(1_000_000),
        .BAUD  (100_000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .data (data),
        .send (send),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // reference model state (written only by the model process)
    bit         m_busy  = 1'b0;
    bit         m_done  = 1'b0;
    int         m_start = 0;
    logic [7:0] m_chars [10];
    logic [7:0] exp_chars[$];
    int         exp_done[$];
    int         reset_cnt = 0;
    int         flush_c   = 0;
    int         flush_d   = 0;

    bit end_req = 1'b0;
    bit end_ack = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input int v);
        logic [7:0] r;
        if (v < 10) r = 8'(48 + v);
        else        r = 8'(55 + v);
        return r;
    endfunction

    // Reference model: evaluated on every rising edge with the inputs the DUT sees.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            m_done = 1'b0;
            if (reset) begin
                m_busy  = 1'b0;
                reset_cnt++;
                flush_c = exp_chars.size();
                flush_d = exp_done.size();
            end else if (send && !m_busy) begin
                m_busy  = 1'b1;
                m_start = cyc;
                for (int i = 0; i < 8; i++)
                    m_chars[i] = hex_char(int'((data >> (28 - 4 * i)) & 32'hF));
                m_chars[8] = 8'h0D;
                m_chars[9] = 8'h0A;
                for (int i = 0; i < N; i++) exp_chars.push_back(m_chars[i]);
                exp_done.push_back(cyc + W);
            end else if (m_busy && cyc == m_start + W) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    // Monitor: per-cycle level checks, done scoreboard, UART line decoder.
    initial begin
        int         seen_rst = 0;
        int         rd_c = 0;
        int         rd_d = 0;
        int         rx_cnt = 0;
        int         t;
        int         b;
        bit         rx_active = 1'b0;
        logic [7:0] rx_byte = 8'h00;
        logic       exp_tx;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                if (reset_cnt != seen_rst) begin
                    seen_rst  = reset_cnt;
                    rx_active = 1'b0;
                    rd_c      = flush_c;
                    rd_d      = flush_d;
                end

                exp_tx = 1'b1;
                if (m_busy) begin
                    t = cyc - m_start;
                    b = (t / DIV) % 10;
                    if (b == 0)     exp_tx = 1'b0;
                    else if (b < 9) exp_tx = m_chars[t / (10 * DIV)][b - 1];
                end
                check("tx_level", 32'(tx), 32'(exp_tx));
                check("busy_level", 32'(busy), 32'(m_busy));
                check("done_level", 32'(done), 32'(m_done));

                if (done === 1'b1) begin
                    if (rd_d < exp_done.size()) begin
                        check("done_cycle", cyc, exp_done[rd_d]);
                        rd_d++;
                    end else begin
                        check("spurious_done", 32'(done), 32'd0);
                    end
                end

                if (rx_active) begin
                    rx_cnt++;
                end else if (tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
                if (rx_active && (rx_cnt % DIV) == DIV / 2) begin
                    b = rx_cnt / DIV;
                    if (b == 0) begin
                        check("start_bit", 32'(tx), 32'd0);
                    end else if (b < 9) begin
                        rx_byte[b - 1] = tx;
                    end else begin
                        check("stop_bit", 32'(tx), 32'd1);
                        if (rd_c < exp_chars.size()) begin
                            check("char", 32'(rx_byte), 32'(exp_chars[rd_c]));
                            rd_c++;
                        end else begin
                            check("extra_char", rd_c + 1, exp_chars.size());
                        end
                        rx_active = 1'b0;
                    end
                end

                if (end_req && !end_ack) begin
                    check("pending_chars", exp_chars.size() - rd_c, 32'd0);
                    check("pending_done", exp_done.size() - rd_d, 32'd0);
                    end_ack = 1'b1;
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        @(posedge clk);
        #2;
        send = 1'b1;
        data = w;
        @(posedge clk);
        #2;
        send = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < W + 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1;
        send  = 1'b0;
        data  = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (5) @(posedge clk);

        send_word(32'h1234ABCD);
        wait_idle();
        send_word(32'h00000000);
        wait_idle();
        send_word(32'h5555AAAA);
        wait_idle();

        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 20)) @(posedge clk);
            send_word($urandom);
            wait_idle();
        end

        // second request at cycle 300 of a word must be ignored
        send_word($urandom);
        repeat (299) @(posedge clk);
        #2;
        send = 1'b1;
        data = 32'hFFFFFFFF;
        @(posedge clk);
        #2 send = 1'b0;
        wait_idle();

        // send held high with data changing every cycle
        @(posedge clk);
        #2 send = 1'b1;
        repeat (3 * W + 10) begin
            data = $urandom;
            @(posedge clk);
            #2;
        end
        send = 1'b0;
        wait_idle();

        // reset mid-frame at cycle 455, then a fresh word
        send_word($urandom);
        repeat (454) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (50) @(posedge clk);
        send_word($urandom);
        wait_idle();

        repeat (20) @(posedge clk);
        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_ack; i++) @(posedge clk);
        if (!end_ack) begin
            $display("FAIL end_handshake: monitor did not acknowledge");
            failed++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mon_uart_tx.md
# mon_uart_tx

Serial debug exporter for the board monitor: captures the 32-bit word the monitor is currently displaying and transmits it as 8 uppercase hex ASCII characters (optionally followed by CR LF) over a 8N1 UART line. It sits downstream of the monitor's display-select mux, in parallel with the seven-segment driver. It runs on the free-running 100 MHz board clock, not on the gated CPU clock.

## Interface
- CLK_HZ, 100_000_000, input clock frequency in Hz
- BAUD, 115_200, line rate; bit period DIV = CLK_HZ/BAUD (integer, truncated), DIV ≥ 2 required
- clk  in  1  board clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high; clock clk
- data  in  32  word to export; sampled only on accepted send
- send  in  1  request; accepted when high on an edge while busy=0
- tx  out  1  UART line, idle high
- busy  out  1  high from the edge that accepts send until the edge that raises done
- done  out  1  one-cycle pulse after the last stop bit of the word completes

## Operation
- Accept: send=1 and busy=0 → latch data into shadow register, char index=0, busy=1. send while busy=1 is ignored (no queueing).
- Character order: nibbles data[31:28] first down to data[3:0]; then 0x0D, 0x0A when CRLF compiled in. N = 10 or 8 characters.
- Hex map: 0–9 → 0x30–0x39; 10–15 → 0x41–0x46.
- Byte framing: start bit 0, 8 data bits LSB first, 1 stop bit 1. No parity.
- Byte FSM states: IDLE, START, DATA, STOP. IDLE→START on load; START→DATA after DIV cycles; DATA→STOP after 8×DIV cycles (bit counter 0..7); STOP→IDLE after DIV cycles, asserting byte_done for one cycle.
- Word sequencer: on byte_done, if index < N−1, increment index and load next byte the same cycle (no idle gap between stop and next start); else drop busy, pulse done.
- Baud counter: counts 0..DIV−1, wraps, reloaded to 0 on every byte load; tx is registered.
- Reset (any time, including mid-frame): tx=1, busy=0, done=0, FSM=IDLE, index=0, counters=0, shadow=0. Aborted frame is not resumed.
- send and reset high together: reset wins, nothing accepted.

## Timing
- Reset values: tx=1, busy=0, done=0.
- Accept on edge k → busy=1 and tx=0 (start bit) both visible after edge k.
- Each bit holds exactly DIV cycles; each character occupies 10×DIV cycles; consecutive characters back-to-back.
- Word length: N×10×DIV cycles from edge k; done high for the single cycle after that, busy=0 in the same cycle as done.
- Earliest next accept: the edge on which done is high (busy already 0).
- At defaults DIV=868; word = 86 800 cycles (CRLF) / 69 440 (no CRLF).

## Configuration
- MON_UART_CRLF_EN defined: N=10, word terminated with 0x0D 0x0A (terminal-friendly line per sample).
- Undefined: N=8, hex digits only, index counter and sequencer compare sized for 8.

## Structure
- Package mon_uart_pkg: byte-FSM state enum (IDLE, START, DATA, STOP), ASCII_CR=8'h0D, ASCII_LF=8'h0A, function hex2ascii(4-bit) → 8-bit.
- Sub-module uart_tx_byte (parameter DIV): byte load/ready handshake, baud counter, bit counter, tx register, byte_done pulse. mon_uart_tx holds the shadow register, character index, mux and done/busy logic.

## Test plan
- CLK_HZ=1_000_000, BAUD=100_000 (DIV=10), CRLF on: data=0x1234ABCD, send one cycle → line decodes 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A; done exactly 1000 cycles after accept edge.
- Same, CRLF off: data=0x00000000 → eight 0x30 characters; done after 800 cycles.
- send held high continuously with data changing each cycle → each word equals data sampled on its own accept edge; gap between words = 0 cycles (new start bit in cycle after done).
- send pulsed again at cycle 300 of a word with data=0xFFFFFFFF → ignored; current word unaffected; no extra done.
- reset asserted at cycle 455 (mid-DATA) → next cycle tx=1, busy=0, done never pulses; fresh send then transmits full word correctly.
- Bit-period check: measure every tx edge in a 0x5555AAAA word → all transitions on multiples of 10 cycles from accept edge.
